// File: rtl/hanoi_engine.sv
// Towers-of-Hanoi move engine: accepts one move request at a time, classifies
// it against the current peg stacks, commits legal moves and reports a result
// code through a valid/ready response channel.
module hanoi_engine #(
  parameter int S = 3,
  parameter int P = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        mv_valid,
  output logic                        mv_ready,
  input  logic [$clog2(P)-1:0]        mv_fr,
  input  logic [$clog2(P)-1:0]        mv_to,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [1:0]                  rsp_err,
  output logic                        done,
  output logic [15:0]                 move_cnt,
  output logic [P*$clog2(S+1)-1:0]    sp_o
);

  localparam int W = $clog2(S + 1);
  localparam int A = $clog2(P);
  localparam logic [A:0] PW = (A + 1)'(P);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RESP  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ERR_OK    = 2'd0,
    ERR_IDX   = 2'd1,
    ERR_EMPTY = 2'd2,
    ERR_ORDER = 2'd3
  } err_e;

  state_e         state;
  logic [A-1:0]   fr_q;
  logic [A-1:0]   to_q;
  logic [W-1:0]   stk [P][S];
  logic [W-1:0]   sp  [P];

  logic [W-1:0]   sp_fr;
  logic [W-1:0]   sp_to;
  logic [W-1:0]   top_fr;
  logic [W-1:0]   top_to;
  err_e           code;

  // Peg lookups are done by scanning rather than variable indexing so that
  // out-of-range peg indices and non-power-of-two depths stay well defined.
  always_comb begin
    sp_fr  = '0;
    sp_to  = '0;
    top_fr = '0;
    top_to = '0;
    for (int unsigned p = 0; p < P; p++) begin
      if (A'(p) == fr_q) begin
        sp_fr = sp[p];
        for (int unsigned i = 0; i < S; i++)
          if (W'(i) + 1'b1 == sp[p]) top_fr = stk[p][i];
      end
      if (A'(p) == to_q) begin
        sp_to = sp[p];
        for (int unsigned i = 0; i < S; i++)
          if (W'(i) + 1'b1 == sp[p]) top_to = stk[p][i];
      end
    end
    if ({1'b0, fr_q} >= PW || {1'b0, to_q} >= PW || fr_q == to_q)
      code = ERR_IDX;
    else if (sp_fr == '0)
      code = ERR_EMPTY;
    else if (sp_to != '0 && top_fr > top_to)
      code = ERR_ORDER;
    else
      code = ERR_OK;
  end

  // Control FSM together with the stack, pointer, counter and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      fr_q      <= '0;
      to_q      <= '0;
      mv_ready  <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= '0;
      done      <= 1'b0;
      move_cnt  <= '0;
      for (int unsigned p = 0; p < P; p++) begin
        sp[p] <= (p == 0) ? W'(S) : '0;
        for (int unsigned i = 0; i < S; i++)
          stk[p][i] <= (p == 0) ? W'(S - i) : '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (mv_valid && mv_ready) begin
            fr_q     <= mv_fr;
            to_q     <= mv_to;
            mv_ready <= 1'b0;
            state    <= CHECK;
          end
        end
        CHECK: begin
          rsp_err   <= code;
          rsp_valid <= 1'b1;
          state     <= RESP;
          if (code == ERR_OK) begin
            for (int unsigned p = 0; p < P; p++) begin
              if (A'(p) == fr_q) sp[p] <= sp_fr - 1'b1;
              if (A'(p) == to_q) sp[p] <= sp_to + 1'b1;
              for (int unsigned i = 0; i < S; i++) begin
                if (A'(p) == fr_q && W'(i) + 1'b1 == sp_fr) stk[p][i] <= '0;
                if (A'(p) == to_q && W'(i) == sp_to)        stk[p][i] <= top_fr;
              end
            end
            if (move_cnt != '1) move_cnt <= move_cnt + 16'd1;
            if (to_q == A'(P - 1) && sp_to + 1'b1 == W'(S)) done <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            mv_ready  <= ~done;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < P; g++) begin : g_sp
    assign sp_o[g*W +: W] = sp[g];
  end

`ifdef FORMAL
  logic [7:0] sp_sum;

  // Ring conservation across all pegs.
  always_comb begin
    sp_sum = '0;
    for (int unsigned p = 0; p < P; p++) sp_sum = sp_sum + 8'(sp[p]);
  end

  // Structural invariants of the puzzle state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (sp_sum == 8'(S));
      for (int unsigned p = 0; p < P; p++) begin
        assert (sp[p] <= W'(S));
        for (int unsigned i = 1; i < S; i++)
          assert (stk[p][i] == '0 || stk[p][i] < stk[p][i-1]);
      end
      cover (done);
    end
  end
`endif

endmodule

// File: tb/tb_hanoi_engine.sv
// Directed bench for hanoi_engine at S=3, P=3.
module tb_hanoi_engine;

  logic       clk;
  logic       rst;
  logic       mv_valid;
  logic       mv_ready;
  logic [1:0] mv_fr;
  logic [1:0] mv_to;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [1:0] rsp_err;
  logic       done;
  logic [15:0] move_cnt;
  logic [5:0] sp_o;

  int checks   = 0;
  int failures = 0;

  hanoi_engine #(.S(3), .P(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .mv_valid  (mv_valid),
    .mv_ready  (mv_ready),
    .mv_fr     (mv_fr),
    .mv_to     (mv_to),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_err   (rsp_err),
    .done      (done),
    .move_cnt  (move_cnt),
    .sp_o      (sp_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mv_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Issue one move; returns the number of cycles from the accept edge to rsp_valid.
  task automatic do_move(input string tag, input logic [1:0] f, input logic [1:0] t,
                         input logic [1:0] exp_err, output int lat);
    int n;
    n = 0;
    while (!mv_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rdy"}, 32'(mv_ready), 1);
    mv_valid = 1'b1;
    mv_fr    = f;
    mv_to    = t;
    @(negedge clk);
    mv_valid = 1'b0;
    mv_fr    = 2'd3;
    mv_to    = 2'd3;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    @(negedge clk);
  endtask

  logic [1:0] sol_fr [7] = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd1, 2'd1, 2'd0};
  logic [1:0] sol_to [7] = '{2'd2, 2'd1, 2'd1, 2'd2, 2'd0, 2'd2, 2'd2};

  initial begin
    int lat;
    rsp_ready = 1'b1;
    mv_fr = '0;
    mv_to = '0;
    do_reset();

    check("rst_ready", 32'(mv_ready), 1);
    check("rst_rvalid", 32'(rsp_valid), 0);
    check("rst_err", 32'(rsp_err), 0);
    check("rst_done", 32'(done), 0);
    check("rst_cnt", 32'(move_cnt), 0);
    check("rst_sp", 32'(sp_o), 3);

    // Empty source peg.
    do_move("empty", 2'd1, 2'd2, 2'd2, lat);
    check("latency", 32'(lat), 2);
    check("empty_sp", 32'(sp_o), 3);
    check("empty_cnt", 32'(move_cnt), 0);

    // Legal move then larger-on-smaller, same peg, out-of-range peg.
    do_move("m01", 2'd0, 2'd1, 2'd0, lat);
    check("m01_sp", 32'(sp_o), 6);
    do_move("order", 2'd0, 2'd1, 2'd3, lat);
    do_move("same", 2'd0, 2'd0, 2'd1, lat);
    do_move("range", 2'd3, 2'd1, 2'd1, lat);
    check("err_cnt", 32'(move_cnt), 1);
    check("err_sp", 32'(sp_o), 6);

    // Reset during CHECK of a legal move.
    do_reset();
    mv_valid = 1'b1;
    mv_fr    = 2'd0;
    mv_to    = 2'd2;
    @(negedge clk);
    mv_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    check("midrst_cnt", 32'(move_cnt), 0);
    check("midrst_sp", 32'(sp_o), 3);
    check("midrst_ready", 32'(mv_ready), 1);
    check("midrst_rvalid", 32'(rsp_valid), 0);

    // Response backpressure with an ignored request in the stall window.
    rsp_ready = 1'b0;
    mv_valid  = 1'b1;
    mv_fr     = 2'd0;
    mv_to     = 2'd2;
    @(negedge clk);
    mv_valid  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("bp_rvalid0", 32'(rsp_valid), 1);
    repeat (2) @(negedge clk);
    mv_valid = 1'b1;
    mv_fr    = 2'd0;
    mv_to    = 2'd1;
    @(negedge clk);
    mv_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("bp_rvalid", 32'(rsp_valid), 1);
    check("bp_err", 32'(rsp_err), 0);
    check("bp_ready", 32'(mv_ready), 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release", 32'(rsp_valid), 0);
    check("bp_cnt", 32'(move_cnt), 1);
    check("bp_sp", 32'(sp_o), 18);

    // Full solution.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      if (i == 6) check("done_before", 32'(done), 0);
      do_move($sformatf("sol%0d", i), sol_fr[i], sol_to[i], 2'd0, lat);
    end
    check("sol_done", 32'(done), 1);
    check("sol_cnt", 32'(move_cnt), 7);
    check("sol_sp", 32'(sp_o), 48);
    check("sol_ready", 32'(mv_ready), 0);

    // No acceptance once solved.
    mv_valid = 1'b1;
    mv_fr    = 2'd2;
    mv_to    = 2'd0;
    repeat (4) @(negedge clk);
    mv_valid = 1'b0;
    check("post_rvalid", 32'(rsp_valid), 0);
    check("post_cnt", 32'(move_cnt), 7);
    check("post_done", 32'(done), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1);
  end

endmodule

// File: doc/hanoi_engine.md
HANOI_ENGINE -- requirements
Module: hanoi_engine

Interface
REQ-001 Parameter S, default 3, number of rings; legal range 1..15.
REQ-002 Parameter P, default 3, number of pegs; legal range 3..8.
REQ-003 Localparams: W = $clog2(S+1), ring/stack-pointer width; A = $clog2(P), peg index width.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 mv_valid  input  1  move request valid.
REQ-007 mv_ready  output  1  engine can accept a move.
REQ-008 mv_fr  input  A  source peg index.
REQ-009 mv_to  input  A  destination peg index.
REQ-010 rsp_valid  output  1  move result valid.
REQ-011 rsp_ready  input  1  result consumed.
REQ-012 rsp_err  output  2  result code: 0 ok, 1 bad index, 2 source empty, 3 larger-on-smaller.
REQ-013 done  output  1  puzzle solved, sticky.
REQ-014 move_cnt  output  16  count of committed legal moves.
REQ-015 sp_o  output  P*W  packed stack pointers, peg p at bits [p*W +: W].

Function
REQ-016 Each peg SHALL hold a stack of S slots of W bits (0 = empty, k = ring size k) plus a W-bit stack pointer (ring count).
REQ-017 FSM states: IDLE, CHECK, RESP.
REQ-018 IDLE: mv_ready=1; mv_valid&mv_ready captures mv_fr/mv_to into registers -> CHECK.
REQ-019 CHECK: mv_ready=0; classify the move in priority order:
  - code 1: index >= P, or fr == to;
  - code 2: sp[fr] == 0;
  - code 3: sp[to] != 0 and top(fr) > top(to);
  - else code 0.
  Code and state update registered on the same edge -> RESP.
REQ-020 Code 0 commit: top(fr) written to slot sp[to] of peg to; slot sp[fr]-1 of peg fr cleared; sp[fr]-1; sp[to]+1; move_cnt+1, saturating at 16'hFFFF.
REQ-021 Codes 1-3: no change to stacks, pointers or move_cnt.
REQ-022 RESP: rsp_valid=1; rsp_err stable until rsp_valid&rsp_ready -> IDLE; mv_ready=0 throughout.
REQ-023 Minimum request-to-response latency 2 cycles: accept edge, then rsp_valid high the cycle after CHECK; throughput 1 move per 3 cycles with rsp_ready tied high.
REQ-024 done SHALL assert on the edge a commit makes sp[P-1] == S, then stay 1 until reset.
REQ-025 While done=1, mv_ready SHALL be 0 in IDLE; no further moves accepted.
REQ-026 mv_fr/mv_to changes while mv_ready=0 SHALL be ignored.
REQ-027 sp_o reflects registered pointers, updated on the commit edge.
REQ-028 Stack pointers never leave 0..S; the sum of all pointers always equals S.

Reset
REQ-029 rst SHALL override any state, including mid-CHECK or mid-RESP; next cycle is IDLE.
REQ-030 Reset values:
  - peg 0 slots i = S-i (bottom S, top 1), sp[0] = S;
  - other pegs all zero;
  - move_cnt = 0, done = 0, rsp_valid = 0, rsp_err = 0;
  - mv_ready = 1 in the first cycle after reset.

Verification
REQ-031 S=3, P=3, rsp_ready=1: moves 0->2,0->1,2->1,0->2,1->0,1->2,0->2 -> seven rsp_err=0; done=1 after 7th commit; move_cnt=7; sp_o: peg2=3, peg0=0, peg1=0.
REQ-032 After reset, 1->2 -> rsp_err=2, sp_o unchanged, move_cnt=0.
REQ-033 After 0->1, then 0->1 -> rsp_err=3 (ring 2 onto ring 1); move 0->0 -> rsp_err=1; mv_fr=3 with P=3 -> rsp_err=1.
REQ-034 rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_err held, mv_ready=0; a mv_valid pulse in that window is not accepted.
REQ-035 rst asserted in the CHECK cycle of a legal move -> no commit; reset state restored; move_cnt=0.
REQ-036 Formal, any S/P: cover done; assert REQ-028 and that no stack ever has a larger ring above a smaller one.
